// File: rtl/rei_pkg.sv
// rtl/rei_pkg.sv - shared widths and enums for the IBUS/DBUS memory arbiter
package rei_pkg;

  localparam int XLEN   = 64;
  localparam int ILEN   = 32;
  localparam int XBYTES = XLEN / 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_OWNER_I = 1'b0,
    ARB_OWNER_D = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/rei_arb_pick.sv
// rtl/rei_arb_pick.sv - two-way request picker producing a one-hot grant
// REI_ARB_RR_EN selects round-robin on ties; otherwise DBUS has fixed priority.
module rei_arb_pick
  import rei_pkg::*;
(
  input  logic ibus_valid,
  input  logic dbus_valid,
`ifdef REI_ARB_RR_EN
  input  logic last_d,
`endif
  output logic gnt_i,
  output logic gnt_d
);

  // A lone requester always wins; only a tie consults the policy.
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
`ifdef REI_ARB_RR_EN
    if (ibus_valid && dbus_valid) begin
      if (last_d) gnt_i = 1'b1;
      else        gnt_d = 1'b1;
    end else begin
      gnt_i = ibus_valid;
      gnt_d = dbus_valid;
    end
`else
    gnt_d = dbus_valid;
    gnt_i = ibus_valid & ~dbus_valid;
`endif
  end

endmodule

// File: rtl/rei_mem_arbiter.sv
// rtl/rei_mem_arbiter.sv - shares one memory port between instruction fetch and data bus
// REI_ARB_RR_EN enables round-robin tie-breaking with a 1-bit last-grant pointer.
module rei_mem_arbiter
  import rei_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ibus_req_valid_i,
  output logic              ibus_req_ready_o,
  input  logic [XLEN-1:0]   ibus_addr_i,
  output logic              ibus_resp_valid_o,
  output logic [ILEN-1:0]   ibus_rdata_o,
  input  logic              dbus_req_valid_i,
  output logic              dbus_req_ready_o,
  input  logic [XLEN-1:0]   dbus_addr_i,
  input  logic              dbus_we_i,
  input  logic [XLEN-1:0]   dbus_wdata_i,
  input  logic [XBYTES-1:0] dbus_wstrb_i,
  output logic              dbus_resp_valid_o,
  output logic [XLEN-1:0]   dbus_rdata_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic              mem_we_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  output logic [XBYTES-1:0] mem_wstrb_o,
  input  logic              mem_resp_valid_i,
  input  logic [XLEN-1:0]   mem_rdata_i
);

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q;
  logic [XLEN-1:0]   addr_q, wdata_q;
  logic              we_q;
  logic [XBYTES-1:0] wstrb_q;
  logic              gnt_i, gnt_d, accept;

`ifdef REI_ARB_RR_EN
  logic last_d_q;

  rei_arb_pick u_pick (
    .ibus_valid (ibus_req_valid_i),
    .dbus_valid (dbus_req_valid_i),
    .last_d     (last_d_q),
    .gnt_i      (gnt_i),
    .gnt_d      (gnt_d)
  );

  // Last-grant pointer; starts as IBUS-last so DBUS takes the first tie.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)     last_d_q <= 1'b0;
    else if (accept) last_d_q <= gnt_d;
  end
`else
  rei_arb_pick u_pick (
    .ibus_valid (ibus_req_valid_i),
    .dbus_valid (dbus_req_valid_i),
    .gnt_i      (gnt_i),
    .gnt_d      (gnt_d)
  );
`endif

  assign accept = (state_q == ARB_IDLE) && (gnt_i || gnt_d);

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= ARB_IDLE;
    else         state_q <= state_d;
  end

  // Capture the winner's payload so the memory sees it stable until handshake.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      owner_q <= ARB_OWNER_I;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (accept) begin
      if (gnt_d) begin
        owner_q <= ARB_OWNER_D;
        addr_q  <= dbus_addr_i;
        we_q    <= dbus_we_i;
        wdata_q <= dbus_wdata_i;
        wstrb_q <= dbus_wstrb_i;
      end else begin
        owner_q <= ARB_OWNER_I;
        addr_q  <= ibus_addr_i;
        we_q    <= 1'b0;
        wdata_q <= '0;
        wstrb_q <= '0;
      end
    end
  end

  assign mem_addr_o  = addr_q;
  assign mem_we_o    = we_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wstrb_o = wstrb_q;

  // Next state plus handshake/response outputs; responses outside ARB_RESP are dropped.
  always_comb begin
    state_d           = state_q;
    ibus_req_ready_o  = 1'b0;
    dbus_req_ready_o  = 1'b0;
    mem_req_valid_o   = 1'b0;
    ibus_resp_valid_o = 1'b0;
    dbus_resp_valid_o = 1'b0;
    ibus_rdata_o      = '0;
    dbus_rdata_o      = '0;
    case (state_q)
      ARB_IDLE: begin
        ibus_req_ready_o = gnt_i;
        dbus_req_ready_o = gnt_d;
        if (gnt_i || gnt_d) state_d = ARB_REQ;
      end
      ARB_REQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) state_d = ARB_RESP;
      end
      ARB_RESP: begin
        if (mem_resp_valid_i) begin
          state_d = ARB_IDLE;
          if (owner_q == ARB_OWNER_D) begin
            dbus_resp_valid_o = 1'b1;
            dbus_rdata_o      = mem_rdata_i;
          end else begin
            ibus_resp_valid_o = 1'b1;
            ibus_rdata_o      = addr_q[2] ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

endmodule
